// File: rtl/rd_ptr_empty.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO.
// The RD_LEVEL_EN macro enables the fill-level and almost-empty outputs.
module rd_ptr_empty #(
  parameter int ADDR_W    = 5,
  parameter int AE_THRESH = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rq2_wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_empty,
  output logic              rd_underflow,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_almost_empty
);

  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] r_ptr;
  logic            r_empty;
  logic            r_underflow;

  logic            w_rinc;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_gray_next;

  assign w_rinc      = rd_en & ~r_empty;
  assign w_bin_next  = r_bin + (ADDR_W+1)'(w_rinc);
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Empty compares the post-read pointer against the current write pointer,
  // so the last read and a concurrent write resolve in a single edge.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_bin       <= '0;
      r_ptr       <= '0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_bin       <= w_bin_next;
      r_ptr       <= w_gray_next;
      r_empty     <= (w_gray_next == rq2_wr_ptr);
      r_underflow <= r_underflow | (rd_en & r_empty);
    end
  end

  assign rd_ptr       = r_ptr;
  assign rd_addr      = r_bin[ADDR_W-1:0];
  assign rd_empty     = r_empty;
  assign rd_underflow = r_underflow;

`ifdef RD_LEVEL_EN
  localparam logic [ADDR_W:0] LP_AE = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] w_wbin;
  logic [ADDR_W:0] w_level_next;
  logic [ADDR_W:0] r_level;
  logic            r_ae;

  always_comb begin
    w_wbin = '0;
    for (int i = 0; i <= ADDR_W; i++) w_wbin[i] = ^(rq2_wr_ptr >> i);
  end

  assign w_level_next = w_wbin - w_bin_next;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_level <= '0;
      r_ae    <= 1'b1;
    end else begin
      r_level <= w_level_next;
      r_ae    <= (w_level_next <= LP_AE);
    end
  end

  assign rd_level        = r_level;
  assign rd_almost_empty = r_ae;
`else
  assign rd_level        = '0;
  assign rd_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Bench for rd_ptr_empty: directed scenarios plus random traffic against a
// counter-based model of reads and writes.
module tb_rd_ptr_empty;
  localparam int ADDR_W = 5;
  localparam int AE     = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PW     = 1 << (ADDR_W + 1);

  logic              rd_clk = 1'b0;
  logic              rd_rst = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W:0]   rq2_wr_ptr = '0;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_empty;
  logic              rd_underflow;
  logic [ADDR_W:0]   rd_level;
  logic              rd_almost_empty;

  rd_ptr_empty #(.ADDR_W(ADDR_W), .AE_THRESH(AE)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .rq2_wr_ptr(rq2_wr_ptr),
    .rd_ptr(rd_ptr), .rd_addr(rd_addr), .rd_empty(rd_empty),
    .rd_underflow(rd_underflow), .rd_level(rd_level),
    .rd_almost_empty(rd_almost_empty)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk = 0;
  int n_err = 0;

  // model: total entries read / written since reset
  int m_r = 0, m_w = 0;
  bit m_empty = 1, m_uf = 0;

  function automatic logic [ADDR_W:0] gray(input int v);
    logic [ADDR_W:0] b;
    b = v[ADDR_W:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int lvl();
    return (m_w - m_r) % PW;
  endfunction

  function automatic bit ae_exp();
`ifdef RD_LEVEL_EN
    return lvl() <= AE;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ptr"},   32'(rd_ptr),          32'(gray(m_r)));
    chk({tag, ".addr"},  32'(rd_addr),         32'(m_r % DEPTH));
    chk({tag, ".empty"}, 32'(rd_empty),        32'(m_empty));
    chk({tag, ".uf"},    32'(rd_underflow),    32'(m_uf));
`ifdef RD_LEVEL_EN
    chk({tag, ".level"}, 32'(rd_level),        32'(lvl()));
`else
    chk({tag, ".level"}, 32'(rd_level),        32'(0));
`endif
    chk({tag, ".ae"},    32'(rd_almost_empty), 32'(ae_exp()));
  endtask

  // Apply inputs on the falling edge, advance the model on the rising edge.
  task automatic step(input bit en, input int w, input string tag);
    bit acc;
    @(negedge rd_clk);
    rd_en = en;
    m_w = w;
    rq2_wr_ptr = gray(w);
    @(posedge rd_clk);
    acc = en && !m_empty;
    m_uf = m_uf | (en && m_empty);
    m_r = m_r + int'(acc);
    m_empty = (lvl() == 0);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge rd_clk);
    #2 rd_rst = 1'b1;
    #1;
    chk({tag, ".ptr"},   32'(rd_ptr),       0);
    chk({tag, ".addr"},  32'(rd_addr),      0);
    chk({tag, ".empty"}, 32'(rd_empty),     1);
    chk({tag, ".uf"},    32'(rd_underflow), 0);
    chk({tag, ".level"}, 32'(rd_level),     0);
`ifdef RD_LEVEL_EN
    chk({tag, ".ae"},    32'(rd_almost_empty), 1);
`else
    chk({tag, ".ae"},    32'(rd_almost_empty), 0);
`endif
    rd_en = 1'b0;
    rq2_wr_ptr = '0;
    m_r = 0; m_w = 0; m_empty = 1; m_uf = 0;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  initial begin
    // reset asserted between clock edges
    do_reset("rst0");

    // drain to empty: 3 entries, 4 read requests
    step(0, 3, "drain.load");
    chk("drain.deassert", 32'(rd_empty), 0);
    step(1, 3, "drain.r1");
    chk("drain.ptr1", 32'(rd_ptr), 32'h01);
    step(1, 3, "drain.r2");
    chk("drain.ptr2", 32'(rd_ptr), 32'h03);
    step(1, 3, "drain.r3");
    chk("drain.ptr3", 32'(rd_ptr), 32'h02);
    chk("drain.empty3", 32'(rd_empty), 1);
    step(1, 3, "drain.r4");
    chk("drain.uf", 32'(rd_underflow), 1);
    chk("drain.ptr4", 32'(rd_ptr), 32'h02);
    step(0, 3, "drain.hold");
    chk("drain.uf_sticky", 32'(rd_underflow), 1);

    // reset mid-read discards the in-flight request
    @(negedge rd_clk);
    rd_en = 1'b1;
    do_reset("rst1");
    step(1, 0, "rst1.empty_read");

    // wrap-around: four bursts of 8 writes then 8 reads
    do_reset("rst2");
    for (int b = 0; b < 4; b++) begin
      step(0, m_w + 8, "wrap.wr");
      for (int k = 0; k < 8; k++) step(1, m_w, "wrap.rd");
    end
    chk("wrap.addr", 32'(rd_addr), 0);
    chk("wrap.ptr", 32'(rd_ptr), 32'h30);
    chk("wrap.empty", 32'(rd_empty), 1);

    // last entry read while the write pointer advances by one
    step(0, m_w + 1, "sim.load");
    begin
      int a0;
      a0 = int'(rd_addr);
      step(1, m_w + 1, "sim.both");
      chk("sim.empty", 32'(rd_empty), 0);
      chk("sim.addr", 32'(rd_addr), 32'((a0 + 1) % DEPTH));
    end

    // levels: 20 entries, then 16 reads
    do_reset("rst3");
    step(0, 20, "lvl.load");
`ifdef RD_LEVEL_EN
    chk("lvl.20", 32'(rd_level), 20);
    chk("lvl.ae20", 32'(rd_almost_empty), 0);
`else
    chk("lvl.off", 32'(rd_level), 0);
`endif
    for (int k = 0; k < 16; k++) step(1, 20, "lvl.rd");
`ifdef RD_LEVEL_EN
    chk("lvl.4", 32'(rd_level), 4);
    chk("lvl.ae4", 32'(rd_almost_empty), 1);
`else
    chk("lvl.off2", 32'(rd_almost_empty), 0);
`endif

    // random traffic: write pointer advances by at most one per cycle
    do_reset("rst4");
    for (int i = 0; i < 600; i++) begin
      int w;
      bit en;
      w = m_w;
      if ((m_w - m_r) < DEPTH && $urandom_range(0, 99) < 45) w = m_w + 1;
      en = ($urandom_range(0, 99) < 55);
      step(en, w, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
